piho_collector: RTL and testbench



---
 rtl/piho_pkg.sv | 35 +++
 rtl/piho_collector_if.sv | 15 +
 rtl/piho_frame_tx.sv | 61 ++++++
 rtl/piho_collector.sv | 159 +++++++++++++++
 tb/tb_piho_collector.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/piho_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piho_pkg
// Brief    : Shared types and constants for the PIHO result collector.
// Revision : 1.0 - initial release
// ============================================================================
package piho_pkg;

   localparam int         X2SUM_W       = 64;
   localparam int         FRAME_LEN     = 10;
   localparam logic [7:0] FRAME_HDR_OK  = 8'hA5;
   localparam logic [7:0] FRAME_HDR_ERR = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GUARD  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_SUM    = 3'd4,
      ST_SEND   = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // XOR of all bytes of a word; this is the frame checksum
   function automatic logic [7:0] xor_bytes(input logic [X2SUM_W-1:0] w);
      logic [7:0] r;
      r = 8'h00;
      for (int b = 0; b < X2SUM_W / 8; b++) begin
         r = r ^ w[8*b +: 8];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piho_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : piho_collector_if
// Brief    : Byte stream towards the host UART transmitter (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
interface piho_collector_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/piho_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : piho_frame_tx
// Brief    : Serialises a 64-bit total into a 10-byte frame:
//            header, 8 bytes LSB first, XOR checksum of those 8 bytes.
// Revision : 1.0 - initial release
// ============================================================================
module piho_frame_tx
   import piho_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [X2SUM_W-1:0] word,
   input  logic               err_flag,
   output logic               frame_done,
   piho_collector_if.master   tx
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
   localparam logic [3:0] CSUM_IDX = 4'(FRAME_LEN - 2);

   logic [3:0]         idx;
   logic [X2SUM_W-1:0] shreg;
   logic [7:0]         csum;

   // Last byte handshake completes the frame in this very cycle
   assign frame_done = tx.tx_valid && tx.tx_ready && (idx == LAST_IDX);

   // Byte sequencer: present the next byte on the cycle after each acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= 8'h00;
         idx         <= 4'd0;
         shreg       <= '0;
         csum        <= 8'h00;
      end else if (load) begin
         tx.tx_valid <= 1'b1;
         tx.tx_data  <= err_flag ? FRAME_HDR_ERR : FRAME_HDR_OK;
         idx         <= 4'd0;
         shreg       <= word;
         csum        <= xor_bytes(word);
      end else if (tx.tx_valid && tx.tx_ready) begin
         if (idx == LAST_IDX) begin
            tx.tx_valid <= 1'b0;
            idx         <= 4'd0;
         end else begin
            idx <= idx + 4'd1;
            if (idx == CSUM_IDX) begin
               tx.tx_data <= csum;
            end else begin
               tx.tx_data <= shreg[7:0];
               shreg      <= shreg >> 8;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/piho_collector.sv
`default_nettype none
// ============================================================================
// Module   : piho_collector
// Brief    : Starts a batch of PIHO units, waits for all finish flags (with
//            guard window and optional timeout), sums their x2sum results
//            and ships the total as a framed byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module piho_collector
   import piho_pkg::*;
#(
   parameter int          NUM_UNITS      = 4,
   parameter int          GUARD_CYCLES   = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [NUM_UNITS-1:0]           unit_finish,
   input  logic [X2SUM_W*NUM_UNITS-1:0]   unit_x2sum,
   output logic                           unit_rst,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [X2SUM_W-1:0]             total_sum,
   piho_collector_if.master               tx
);

   localparam int                   IDX_W        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam logic [IDX_W-1:0]     SUM_LAST     = IDX_W'(NUM_UNITS - 1);
   localparam logic [7:0]           GUARD_LAST   = 8'(GUARD_CYCLES - 1);
   localparam logic [NUM_UNITS-1:0] ALL_DONE     = {NUM_UNITS{1'b1}};
   localparam bit                   TIMEOUT_EN   = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [31:0]          TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

   state_t               state;
   logic [7:0]           guard_cnt;
   logic [31:0]          tmo_cnt;
   logic [NUM_UNITS-1:0] mask;
   logic                 settle_cnt;
   logic [IDX_W-1:0]     sum_idx;
   logic [X2SUM_W-1:0]   acc;

   logic [X2SUM_W-1:0]   x2sum_arr [NUM_UNITS];
   logic [NUM_UNITS-1:0] mask_next;
   logic [X2SUM_W-1:0]   acc_next;
   logic                 frame_load;
   logic                 frame_done;

   for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unpack
      assign x2sum_arr[gi] = unit_x2sum[X2SUM_W*gi +: X2SUM_W];
   end

   // Sticky finish mask, running sum (wraps mod 2^64) and frame load strobe
   always_comb begin
      mask_next  = mask | unit_finish;
      acc_next   = acc + (mask[sum_idx] ? x2sum_arr[sum_idx] : {X2SUM_W{1'b0}});
      frame_load = (state == ST_SUM) && (sum_idx == SUM_LAST);
   end

   piho_frame_tx u_frame_tx (
      .clk        (clk),
      .rst        (rst),
      .load       (frame_load),
      .word       (acc_next),
      .err_flag   (err),
      .frame_done (frame_done),
      .tx         (tx)
   );

   // Batch control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         unit_rst   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         total_sum  <= '0;
         guard_cnt  <= 8'd0;
         tmo_cnt    <= 32'd0;
         mask       <= '0;
         settle_cnt <= 1'b0;
         sum_idx    <= '0;
         acc        <= '0;
      end else begin
         unit_rst <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_GUARD;
                  unit_rst  <= 1'b1;
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  guard_cnt <= 8'd0;
                  tmo_cnt   <= 32'd0;
                  mask      <= '0;
               end
            end
            ST_GUARD: begin
               // finish levels may still be stale from the previous run here
               if (guard_cnt == GUARD_LAST) begin
                  state <= ST_WAIT;
               end else begin
                  guard_cnt <= guard_cnt + 8'd1;
               end
            end
            ST_WAIT: begin
               mask       <= mask_next;
               settle_cnt <= 1'b0;
               // completion takes priority over a coincident timeout
               if (mask_next == ALL_DONE) begin
                  state <= ST_SETTLE;
               end else if (TIMEOUT_EN && (tmo_cnt == TIMEOUT_LAST)) begin
                  err   <= 1'b1;
                  state <= ST_SETTLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            ST_SETTLE: begin
               // two cycles for the units' x2sum_real register to catch up
               if (settle_cnt) begin
                  state   <= ST_SUM;
                  sum_idx <= '0;
                  acc     <= '0;
               end else begin
                  settle_cnt <= 1'b1;
               end
            end
            ST_SUM: begin
               acc <= acc_next;
               if (sum_idx == SUM_LAST) begin
                  total_sum <= acc_next;
                  state     <= ST_SEND;
               end else begin
                  sum_idx <= sum_idx + 1'b1;
               end
            end
            ST_SEND: begin
               if (frame_done) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_piho_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_piho_collector
// Brief    : Directed self-checking bench for piho_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piho_collector;

   localparam int NU = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [NU-1:0]     unit_finish;
   logic [64*NU-1:0]  unit_x2sum;
   logic              unit_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic [63:0]       total_sum;

   piho_collector_if bus ();

   piho_collector #(
      .NUM_UNITS      (NU),
      .GUARD_CYCLES   (4),
      .TIMEOUT_CYCLES (32'd100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .unit_finish (unit_finish),
      .unit_x2sum  (unit_x2sum),
      .unit_rst    (unit_rst),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .total_sum   (total_sum),
      .tx          (bus)
   );

   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;

   // Unit model: ucnt is the cycle index since the last unit_rst cycle (0)
   int         ucnt = 1000;
   int         fin_at [NU];
   logic       stale = 1'b0;

   logic [7:0] got [$];
   int         done_cnt = 0;
   int         urst_cnt = 0;
   logic       hold_prev = 1'b0;
   logic [7:0] hold_data = 8'h00;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycle counter of the unit model, advanced at mid-cycle
   always @(negedge clk) begin
      if (unit_rst === 1'b1) ucnt = 0;
      else if (ucnt < 100000) ucnt = ucnt + 1;
   end

   // Units hold a stale finish for two cycles after reset, then raise it at fin_at
   always_comb begin
      for (int i = 0; i < NU; i++) begin
         unit_finish[i] = (stale && (ucnt < 2)) || ((fin_at[i] >= 0) && (ucnt >= fin_at[i]));
      end
   end

   // Stream monitor: records handshakes, checks hold stability, counts pulses
   always @(negedge clk) begin
      #2;
      if (hold_prev) begin
         chk("hold_valid", 64'(bus.tx_valid), 64'd1);
         chk("hold_data", 64'(bus.tx_data), 64'(hold_data));
      end
      hold_prev = bus.tx_valid && !bus.tx_ready && !rst;
      hold_data = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready && !rst) got.push_back(bus.tx_data);
      if (done === 1'b1) done_cnt++;
      if (unit_rst === 1'b1) urst_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_sums(input logic [63:0] s0, input logic [63:0] s1,
                           input logic [63:0] s2, input logic [63:0] s3);
      unit_x2sum = {s3, s2, s1, s0};
   endtask

   task automatic set_fin(input int f0, input int f1, input int f2, input int f3);
      fin_at[0] = f0; fin_at[1] = f1; fin_at[2] = f2; fin_at[3] = f3;
   endtask

   // One-cycle start; returns in the unit_rst cycle
   task automatic launch();
      got.delete();
      done_cnt = 0;
      urst_cnt = 0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rnd);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      bus.tx_ready = 1'b1;
      chk("done_within_budget", 64'(done), 64'd1);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("valid_at_done", 64'(bus.tx_valid), 64'd0);
   endtask

   task automatic check_frame(input logic [7:0] hdr, input logic [63:0] sum, input logic [7:0] cs);
      logic [7:0] exp [10];
      logic [7:0] obs;
      exp[0] = hdr;
      for (int b = 1; b <= 8; b++) exp[b] = sum[8*(b-1) +: 8];
      exp[9] = cs;
      chk("frame_len", 64'(got.size()), 64'd10);
      for (int b = 0; b < 10; b++) begin
         obs = (b < got.size()) ? got[b] : 8'hxx;
         chk($sformatf("byte%0d", b), 64'(obs), 64'(exp[b]));
      end
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      start        = 1'b0;
      bus.tx_ready = 1'b1;
      unit_x2sum   = '0;
      set_fin(0, 0, 0, 0);
      repeat (3) tick();

      // reset state
      chk("rst_unit_rst", 64'(unit_rst), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_total", total_sum, 64'd0);
      chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
      chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
      rst = 1'b0;
      tick();

      // basic run: 1+2+3+4, all finish 20 cycles after unit_rst
      set_sums(64'd1, 64'd2, 64'd3, 64'd4);
      set_fin(20, 20, 20, 20);
      launch();
      chk("t1_unit_rst", 64'(unit_rst), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_err", 64'(err), 64'd0);
      tick();
      chk("t1_unit_rst_1cyc", 64'(unit_rst), 64'd0);
      run_until_done(200, 1'b0);
      chk("t1_latency", 64'(ucnt), 64'd37);
      chk("t1_total", total_sum, 64'd10);
      chk("t1_err_end", 64'(err), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(done), 64'd0);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);
      check_frame(8'hA5, 64'd10, 8'h0A);

      // stale finish during guard, real finish 50 cycles after it drops
      stale = 1'b1;
      set_fin(52, 52, 52, 52);
      launch();
      tick();
      run_until_done(300, 1'b0);
      chk("t2_latency", 64'(ucnt), 64'd69);
      chk("t2_total", total_sum, 64'd10);
      tick();
      chk("t2_urst_cnt", 64'(urst_cnt), 64'd1);
      chk("t2_done_cnt", 64'(done_cnt), 64'd1);
      stale = 1'b0;

      // timeout: unit 2 never finishes
      set_sums(64'd5, 64'd6, 64'd7, 64'd8);
      set_fin(20, 20, -1, 20);
      launch();
      tick();
      run_until_done(400, 1'b0);
      chk("t3_latency", 64'(ucnt), 64'd120);
      chk("t3_err", 64'(err), 64'd1);
      chk("t3_total", total_sum, 64'd19);
      tick();
      check_frame(8'hEE, 64'd19, 8'h13);

      // 64-bit wrap; next start also clears err
      set_sums(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0);
      set_fin(10, 10, 10, 10);
      launch();
      chk("t4_err_cleared", 64'(err), 64'd0);
      tick();
      run_until_done(200, 1'b0);
      chk("t4_latency", 64'(ucnt), 64'd27);
      chk("t4_total", total_sum, 64'd1);
      tick();
      check_frame(8'hA5, 64'd1, 8'h01);

      // random backpressure
      set_sums(64'h0102_0304_0506_0708, 64'h10, 64'h20, 64'd0);
      launch();
      tick();
      run_until_done(500, 1'b1);
      chk("t5_total", total_sum, 64'h0102_0304_0506_0738);
      tick();
      chk("t5_done_cnt", 64'(done_cnt), 64'd1);
      check_frame(8'hA5, 64'h0102_0304_0506_0738, 8'h38);

      // start while busy is ignored; rst while byte 4 is pending
      set_sums(64'd1, 64'd2, 64'd3, 64'd4);
      launch();
      n = 0;
      while (ucnt != 6 && n < 50) begin tick(); n++; end
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (ucnt != 21 && n < 50) begin tick(); n++; end
      chk("t6_byte4_valid", 64'(bus.tx_valid), 64'd1);
      chk("t6_byte4_data", 64'(bus.tx_data), 64'h00);
      rst          = 1'b1;
      bus.tx_ready = 1'b0;
      tick();
      rst          = 1'b0;
      bus.tx_ready = 1'b1;
      chk("t6_rst_valid", 64'(bus.tx_valid), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_unit_rst", 64'(unit_rst), 64'd0);
      chk("t6_bytes_before_rst", 64'(got.size()), 64'd4);
      chk("t6_urst_cnt", 64'(urst_cnt), 64'd1);
      tick();
      tick();
      chk("t6_idle_valid", 64'(bus.tx_valid), 64'd0);
      chk("t6_no_done", 64'(done_cnt), 64'd0);

      // clean run after the abandoned frame
      launch();
      tick();
      run_until_done(200, 1'b0);
      chk("t7_latency", 64'(ucnt), 64'd27);
      chk("t7_total", total_sum, 64'd10);
      tick();
      chk("t7_done_cnt", 64'(done_cnt), 64'd1);
      chk("t7_urst_cnt", 64'(urst_cnt), 64'd1);
      check_frame(8'hA5, 64'd10, 8'h0A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
